adsr_envelope: RTL

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

---
 rtl/synth_pkg.sv | 25 ++
 rtl/adsr_envelope_if.sv | 40 ++++
 rtl/env_scaler.sv | 70 +++++++
 rtl/adsr_envelope.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synth_pkg                                                            |
// | Shared types and constants for the synthesizer envelope datapath.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package synth_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int ENV_W_DEF    = 12;
  localparam int RATE_W_DEF   = 8;

  localparam logic [15:0] MIDSCALE = 16'h8000;
  localparam logic [11:0] ENV_MAX  = 12'd4095;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

endpackage : synth_pkg
`default_nettype wire

// File: rtl/adsr_envelope_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adsr_envelope_if                                                     |
// | Control, sample and status bundle of the ADSR envelope generator.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface adsr_envelope_if
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ENV_W    = ENV_W_DEF,
  parameter int RATE_W   = RATE_W_DEF
);

  logic                tick;
  logic                gate;
  logic [RATE_W-1:0]   attack_rate;
  logic [RATE_W-1:0]   decay_rate;
  logic [RATE_W-1:0]   release_rate;
  logic [ENV_W-1:0]    sustain_level;
  logic [SAMPLE_W-1:0] sample_in;

  logic [SAMPLE_W-1:0] sample_out;
  logic                out_valid;
  logic [ENV_W-1:0]    env_level;
  logic [2:0]          state;
  logic                busy;

  modport master (
    output tick, gate, attack_rate, decay_rate, release_rate, sustain_level, sample_in,
    input  sample_out, out_valid, env_level, state, busy
  );

  modport slave (
    input  tick, gate, attack_rate, decay_rate, release_rate, sustain_level, sample_in,
    output sample_out, out_valid, env_level, state, busy
  );

endinterface : adsr_envelope_if
`default_nettype wire

// File: rtl/env_scaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | env_scaler                                                           |
// | Two-stage pipeline scaling an offset-binary sample by the envelope.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module env_scaler
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ENV_W    = ENV_W_DEF
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [ENV_W-1:0]    env,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                out_valid
);

  localparam int                  c_prod_w   = SAMPLE_W + ENV_W + 2;
  localparam logic [ENV_W-1:0]    c_env_max  = {ENV_W{1'b1}};
  localparam logic [SAMPLE_W-1:0] c_midscale = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [ENV_W:0]             w_scale;
  logic signed [c_prod_w-1:0] w_sample_ext;
  logic signed [c_prod_w-1:0] w_scale_ext;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_prod_w-1:0] r_prod;
  logic                       r_prod_valid;
  logic [SAMPLE_W-1:0]        r_sample_out;
  logic                       r_out_valid;
  logic                       w_unused_prod;

  // Full scale maps to exactly 1.0 so a peak envelope passes the sample unchanged
  assign w_scale = (env == c_env_max) ? {1'b1, {ENV_W{1'b0}}} : {1'b0, env};

  // Flipping the MSB turns offset binary into two's complement
  assign w_sample_ext = {{(ENV_W+2){~sample_in[SAMPLE_W-1]}},
                         ~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0]};
  assign w_scale_ext  = {{(SAMPLE_W+1){1'b0}}, w_scale};
  assign w_prod       = w_sample_ext * w_scale_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod       <= '0;
      r_prod_valid <= 1'b0;
      r_sample_out <= c_midscale;
      r_out_valid  <= 1'b0;
    end else begin
      r_prod_valid <= tick;
      if (tick) begin
        r_prod <= w_prod;
      end
      r_out_valid <= r_prod_valid;
      // Bit slice is the floor shift by ENV_W; MSB flip re-adds midscale
      if (r_prod_valid) begin
        r_sample_out <= {~r_prod[ENV_W+SAMPLE_W-1], r_prod[ENV_W+SAMPLE_W-2:ENV_W]};
      end
    end
  end

  assign w_unused_prod = ^{r_prod[c_prod_w-1:ENV_W+SAMPLE_W], r_prod[ENV_W-1:0]};

  assign sample_out = r_sample_out;
  assign out_valid  = r_out_valid;

endmodule : env_scaler
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adsr_envelope                                                        |
// | ADSR envelope FSM and level update, feeding the sample scaler.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ENV_W    = ENV_W_DEF,
  parameter int RATE_W   = RATE_W_DEF
)(
  input  logic           clk,
  input  logic           rst_n,
  adsr_envelope_if.slave bus
);

  localparam logic [ENV_W-1:0] c_env_max = {ENV_W{1'b1}};

  adsr_state_t      r_state;
  adsr_state_t      w_state_nxt;
  adsr_state_t      w_phase;
  logic [ENV_W-1:0] r_env;
  logic [ENV_W-1:0] w_env_nxt;
  logic             r_gate_prev;
  logic             w_rise;
  logic             w_gate_off;
  logic [ENV_W:0]   w_att_step;
  logic [ENV_W:0]   w_dec_step;
  logic [ENV_W:0]   w_rel_step;
  logic [ENV_W:0]   w_sum;
  logic [ENV_W:0]   w_dec_diff;
  logic [ENV_W:0]   w_rel_diff;

  // One extra bit catches overflow past full scale and borrow below zero
  assign w_att_step = {{(ENV_W+1-RATE_W){1'b0}}, bus.attack_rate};
  assign w_dec_step = {{(ENV_W+1-RATE_W){1'b0}}, bus.decay_rate};
  assign w_rel_step = {{(ENV_W+1-RATE_W){1'b0}}, bus.release_rate};
  assign w_sum      = {1'b0, r_env} + w_att_step;
  assign w_dec_diff = {1'b0, r_env} - w_dec_step;
  assign w_rel_diff = {1'b0, r_env} - w_rel_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_env       <= '0;
      r_gate_prev <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
      if (bus.tick) begin
        r_gate_prev <= bus.gate;
      end
    end
  end

  // Gate events pick the phase that governs this tick before level rules run
  always_comb begin
    w_rise     = bus.gate & ~r_gate_prev;
    w_gate_off = ~bus.gate & ((r_state == ST_ATTACK) | (r_state == ST_DECAY) |
                              (r_state == ST_SUSTAIN));
    w_phase    = r_state;
    if (w_rise) begin
      w_phase = ST_ATTACK;
    end else if (w_gate_off) begin
      w_phase = ST_RELEASE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (bus.tick) begin
      w_state_nxt = w_phase;
      case (w_phase)
        ST_IDLE: begin
          w_env_nxt = '0;
        end
        ST_ATTACK: begin
          if (bus.attack_rate != '0) begin
            if (w_sum >= {1'b0, c_env_max}) begin
              w_env_nxt   = c_env_max;
              w_state_nxt = ST_DECAY;
            end else begin
              w_env_nxt = w_sum[ENV_W-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (bus.decay_rate != '0) begin
            if (w_dec_diff[ENV_W] || (w_dec_diff[ENV_W-1:0] <= bus.sustain_level)) begin
              w_env_nxt   = bus.sustain_level;
              w_state_nxt = ST_SUSTAIN;
            end else begin
              w_env_nxt = w_dec_diff[ENV_W-1:0];
            end
          end
        end
        ST_SUSTAIN: begin
          w_env_nxt = bus.sustain_level;
        end
        ST_RELEASE: begin
          if (bus.release_rate != '0) begin
            if (w_rel_diff[ENV_W] || (w_rel_diff[ENV_W-1:0] == '0)) begin
              w_env_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_env_nxt = w_rel_diff[ENV_W-1:0];
            end
          end
        end
        default: begin
          w_env_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.busy      = (r_state != ST_IDLE);
    bus.state     = r_state;
    bus.env_level = r_env;
  end

  // Scaler sees the pre-update level of the tick cycle
  env_scaler #(
    .SAMPLE_W (SAMPLE_W),
    .ENV_W    (ENV_W)
  ) u_env_scaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (bus.tick),
    .sample_in  (bus.sample_in),
    .env        (r_env),
    .sample_out (bus.sample_out),
    .out_valid  (bus.out_valid)
  );

endmodule : adsr_envelope
`default_nettype wire
